axi_full_s_ram: RTL
===================

// Module: axi_full_s_ram
// PURPOSE
//  AXI4 full slave memory that terminates the CPU-side AXI burst master at base 0x8000_0000.
//  Serves the AW/W/B and AR/R channels independently, supports FIXED and INCR bursts of 1..256 beats,
//  and applies WSTRB byte enables. Acts as the simulation/FPGA main-memory stage downstream of the master.
// PARAMETERS
//  C_S_BASE_ADDR        32'h8000_0000  first byte address decoded by this slave
//  C_S_AXI_ID_WIDTH     1              AxID/xID width
//  C_S_AXI_ADDR_WIDTH   32             address width
//  C_S_AXI_DATA_WIDTH   32             data width (32 or 64)
//  C_S_MEM_DEPTH        4096           words of storage; word = DATA_WIDTH bits
// PORTS
//  S_AXI_ACLK     in   1   clock, all logic on rising edge
//  S_AXI_ARESET   in   1   reset, synchronous, active-high
//  S_AXI_AWID/AWADDR/AWLEN[8]/AWSIZE[3]/AWBURST[2]   in   write address fields
//  S_AXI_AWVALID  in 1 / S_AXI_AWREADY out 1          write address handshake
//  S_AXI_WDATA in DW / S_AXI_WSTRB in DW/8 / S_AXI_WLAST in 1 / S_AXI_WVALID in 1 / S_AXI_WREADY out 1
//  S_AXI_BID out IDW / S_AXI_BRESP out 2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1
//  S_AXI_ARID/ARADDR/ARLEN[8]/ARSIZE[3]/ARBURST[2]   in   read address fields
//  S_AXI_ARVALID  in 1 / S_AXI_ARREADY out 1
//  S_AXI_RID out IDW / S_AXI_RDATA out DW / S_AXI_RRESP out 2 / S_AXI_RLAST out 1 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1
// BEHAVIOUR
//  Reset: AWREADY/WREADY/BVALID/ARREADY/RVALID/RLAST=0, BRESP/RRESP/BID/RID/RDATA=0; both FSMs -> IDLE.
//   Memory contents NOT reset. Reset mid-burst aborts it silently (no B/R completion); beats already written stay.
//  Word index = (ADDR - C_S_BASE_ADDR) >> log2(DW/8); beats = LEN+1; INCR adds 1 per beat, FIXED holds index.
//  Write FSM: W_IDLE (AWREADY=1) -AW hs-> W_DATA (WREADY=1) -W hs with WLAST-> W_RESP (BVALID=1) -BREADY-> W_IDLE.
//   AW hs latches AWID/index/LEN/BURST/SIZE and clears beat counter and error flags.
//   Each W hs: if index < C_S_MEM_DEPTH and no size error, write bytes where WSTRB=1; beat counter +1.
//   BRESP = worst over burst, DECERR(11) > SLVERR(10) > OKAY(00):
//    DECERR: any beat index out of range (that beat not written; in-range beats are written).
//    SLVERR: AWSIZE != log2(DW/8) (no beats written), AWBURST = WRAP/reserved (treated as INCR),
//            WLAST on beat != LEN, or beat counter passes LEN without WLAST (extra beats discarded).
//   BID = latched AWID. AW accepted only in W_IDLE, so the next AW waits until the B handshake.
//  Read FSM: R_IDLE (ARREADY=1) -AR hs-> R_DATA -R hs with RLAST-> R_IDLE.
//   RDATA/RRESP/RLAST are registers loaded on the AR hs edge (beat 0) and on each non-last R hs (next beat).
//    Latency: AR hs in cycle T -> RVALID with beat 0 in T+1; back-to-back beats with RREADY held high.
//   RVALID=0 -> stall: RDATA/RRESP/RLAST/RID held stable (AXI rule) even if memory is written meanwhile.
//   Per-beat RRESP: out-of-range -> DECERR, RDATA=0; size/burst error -> SLVERR on every beat, RDATA=0 on size error.
//   RLAST=1 exactly on beat LEN. RID = latched ARID. Next AR is accepted in the cycle after the RLAST hs.
//  Simultaneous events: channels fully concurrent. A write and read beat to the same word in one cycle: the read
//   register captures OLD data and the new data is visible to later reads. Address arithmetic is done in
//   C_S_AXI_ADDR_WIDTH bits; ADDR < BASE wraps large and decodes DECERR. Beat counter is 9 bits so LEN=255 never overflows.
// STRUCTURE
//  Shared package axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/EXOKAY/SLVERR/DECERR, write/read FSM state
//   encodings, clogb2 function.
//  Sub-module axi_s_ram_array: one write port (word index, byte enables) and one registered read port,
//   depth/width parameters; storage only. Top level holds the two FSMs, counters and response logic.
// TESTING
//  1 single write AW=0x8000_0010 LEN=0 WSTRB=F WDATA=0xDEADBEEF -> BRESP=00, BID=AWID; AR same, LEN=0 -> RDATA=0xDEADBEEF, RLAST=1, RVALID at T+1.
//  2 INCR LEN=15 write data 1..16 at 0x8000_0000, RREADY toggled randomly on readback -> 16 beats 1..16 in order, RLAST only on 16th, data stable while stalled.
//  3 WSTRB=4'b0101 data 0x11223344 over 0xFFFFFFFF -> readback 0xFF22FF44; FIXED LEN=3 write 1,2,3,4 -> word holds 4.
//  4 AWADDR=0x7FFF_FFFC and INCR crossing C_S_MEM_DEPTH end -> BRESP=11, in-range beats written; read of same -> RRESP=11 and RDATA=0 on bad beats.
//  5 WLAST early on beat 2 of LEN=3 -> BRESP=10, next AW accepted after B hs; AWSIZE=1 -> BRESP=10, memory unchanged.
//  6 reset asserted mid read burst and mid write burst -> RVALID/BVALID=0 next cycle, AW/ARREADY=1 after release, memory keeps prior data.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, FSM state types and a ceil-log2 helper used by the
// AXI slave memory and its storage array.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_s_ram_array.sv
// Byte-lane word memory: one write port with byte enables and one registered
// read port. Read during write to the same word returns the old contents.
module axi_s_ram_array
  import axi_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int DW    = 32,
  parameter int MW    = 12
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [MW-1:0]   i_waddr,
  input  logic [DW/8-1:0] i_wbe,
  input  logic [DW-1:0]   i_wdata,
  input  logic            i_re,
  input  logic [MW-1:0]   i_raddr,
  output logic [DW-1:0]   o_rdata
);

  // One independent byte-wide array per lane so each byte enable is a plain write enable.
  for (genvar gi = 0; gi < DW / 8; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_we && i_wbe[gi]) r_mem[i_waddr] <= i_wdata[gi*8 +: 8];
      if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_rdata[gi*8 +: 8] = r_q;
  end

endmodule

// File: rtl/axi_full_s_ram.sv
// AXI4 full slave memory: independent write (AW/W/B) and read (AR/R) FSMs with
// FIXED/INCR bursts, byte strobes and DECERR/SLVERR reporting.
module axi_full_s_ram
  import axi_pkg::*;
#(
  parameter logic [31:0] C_S_BASE_ADDR      = 32'h8000_0000,
  parameter int          C_S_AXI_ID_WIDTH   = 1,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_MEM_DEPTH      = 4096
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SH = clogb2(DW / 8);
  localparam int MW = clogb2(C_S_MEM_DEPTH);
  localparam logic [AW-1:0] BASE    = AW'(C_S_BASE_ADDR);
  localparam logic [AW-1:0] DEPTH   = AW'(C_S_MEM_DEPTH);
  localparam logic [2:0]    SIZE_OK = 3'(SH);

  // ---------------- write channel ----------------
  wr_state_t r_wr_state, w_wr_state_next;
  logic [C_S_AXI_ID_WIDTH-1:0] r_bid;
  logic [AW-1:0] r_wr_idx, w_aw_off;
  logic [7:0]    r_wr_len;
  logic [8:0]    r_wr_cnt;
  logic r_wr_fixed, r_wr_size_err, r_wr_slverr, r_wr_decerr;
  logic w_aw_hs, w_w_hs, w_wr_in_range, w_wr_beat_ok, w_wr_en;

  assign w_aw_off      = S_AXI_AWADDR - BASE;
  assign w_aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs        = S_AXI_WVALID && S_AXI_WREADY;
  assign w_wr_in_range = r_wr_idx < DEPTH;
  assign w_wr_beat_ok  = r_wr_cnt <= {1'b0, r_wr_len};
  assign w_wr_en       = w_w_hs && w_wr_beat_ok && w_wr_in_range && !r_wr_size_err;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) r_wr_state <= W_IDLE;
    else              r_wr_state <= w_wr_state_next;
  end

  always_comb begin
    w_wr_state_next = r_wr_state;
    S_AXI_AWREADY   = 1'b0;
    S_AXI_WREADY    = 1'b0;
    S_AXI_BVALID    = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        S_AXI_AWREADY = !S_AXI_ARESET;
        if (S_AXI_AWVALID && !S_AXI_ARESET) w_wr_state_next = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = !S_AXI_ARESET;
        if (S_AXI_WVALID && S_AXI_WLAST) w_wr_state_next = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_wr_state_next = W_IDLE;
      end
      default: w_wr_state_next = W_IDLE;
    endcase
  end

  // Beats past LEN are swallowed without writing and flag SLVERR; the counter parks at LEN+1.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_bid <= '0;
    end else if (w_aw_hs) begin
      r_bid         <= S_AXI_AWID;
      r_wr_idx      <= w_aw_off >> SH;
      r_wr_len      <= S_AXI_AWLEN;
      r_wr_cnt      <= 9'd0;
      r_wr_fixed    <= (S_AXI_AWBURST == BURST_FIXED);
      r_wr_size_err <= (S_AXI_AWSIZE != SIZE_OK);
      r_wr_slverr   <= (S_AXI_AWSIZE != SIZE_OK) ||
                       (S_AXI_AWBURST != BURST_FIXED && S_AXI_AWBURST != BURST_INCR);
      r_wr_decerr   <= 1'b0;
    end else if (w_w_hs) begin
      if (w_wr_beat_ok) begin
        if (!w_wr_in_range) r_wr_decerr <= 1'b1;
        if (S_AXI_WLAST != (r_wr_cnt == {1'b0, r_wr_len})) r_wr_slverr <= 1'b1;
        r_wr_cnt <= r_wr_cnt + 9'd1;
        if (!r_wr_fixed) r_wr_idx <= r_wr_idx + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        r_wr_slverr <= 1'b1;
      end
    end
  end

  assign S_AXI_BID   = r_bid;
  assign S_AXI_BRESP = (r_wr_state != W_RESP) ? RESP_OKAY :
                       r_wr_decerr ? RESP_DECERR :
                       r_wr_slverr ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read channel ----------------
  rd_state_t r_rd_state, w_rd_state_next;
  logic [C_S_AXI_ID_WIDTH-1:0] r_rid;
  logic [AW-1:0] r_rd_idx, w_ar_off, w_ld_idx;
  logic [7:0]    r_rd_len, w_ld_len;
  logic [8:0]    r_rd_cnt, w_ld_cnt;
  logic [1:0]    r_rresp;
  logic r_rd_fixed, r_rd_size_err, r_rd_burst_err, r_rlast, r_rd_zero;
  logic w_ld_fixed, w_ld_size_err, w_ld_burst_err, w_ld_in_range;
  logic w_ar_hs, w_r_hs, w_ld;
  logic [DW-1:0] w_ram_q;

  assign w_ar_off = S_AXI_ARADDR - BASE;
  assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_r_hs   = S_AXI_RVALID && S_AXI_RREADY;
  assign w_ld     = w_ar_hs || (w_r_hs && !r_rlast);

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) r_rd_state <= R_IDLE;
    else              r_rd_state <= w_rd_state_next;
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    S_AXI_ARREADY   = 1'b0;
    S_AXI_RVALID    = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        S_AXI_ARREADY = !S_AXI_ARESET;
        if (S_AXI_ARVALID && !S_AXI_ARESET) w_rd_state_next = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY && r_rlast) w_rd_state_next = R_IDLE;
      end
      default: w_rd_state_next = R_IDLE;
    endcase
  end

  // Describes the beat about to be loaded: beat 0 from AR, otherwise the successor of the current beat.
  always_comb begin
    if (r_rd_state == R_IDLE) begin
      w_ld_idx       = w_ar_off >> SH;
      w_ld_cnt       = 9'd0;
      w_ld_len       = S_AXI_ARLEN;
      w_ld_fixed     = (S_AXI_ARBURST == BURST_FIXED);
      w_ld_size_err  = (S_AXI_ARSIZE != SIZE_OK);
      w_ld_burst_err = (S_AXI_ARBURST != BURST_FIXED && S_AXI_ARBURST != BURST_INCR);
    end else begin
      w_ld_idx       = r_rd_idx + {{(AW-1){1'b0}}, !r_rd_fixed};
      w_ld_cnt       = r_rd_cnt + 9'd1;
      w_ld_len       = r_rd_len;
      w_ld_fixed     = r_rd_fixed;
      w_ld_size_err  = r_rd_size_err;
      w_ld_burst_err = r_rd_burst_err;
    end
  end

  assign w_ld_in_range = w_ld_idx < DEPTH;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_rid     <= '0;
      r_rresp   <= RESP_OKAY;
      r_rlast   <= 1'b0;
      r_rd_zero <= 1'b1;
    end else if (w_ld) begin
      if (w_ar_hs) r_rid <= S_AXI_ARID;
      r_rd_idx       <= w_ld_idx;
      r_rd_cnt       <= w_ld_cnt;
      r_rd_len       <= w_ld_len;
      r_rd_fixed     <= w_ld_fixed;
      r_rd_size_err  <= w_ld_size_err;
      r_rd_burst_err <= w_ld_burst_err;
      r_rlast        <= (w_ld_cnt == {1'b0, w_ld_len});
      r_rresp        <= !w_ld_in_range ? RESP_DECERR :
                        (w_ld_size_err || w_ld_burst_err) ? RESP_SLVERR : RESP_OKAY;
      r_rd_zero      <= !w_ld_in_range || w_ld_size_err;
    end
  end

  axi_s_ram_array #(
    .DEPTH (C_S_MEM_DEPTH),
    .DW    (DW),
    .MW    (MW)
  ) u_ram (
    .clk     (S_AXI_ACLK),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_idx[MW-1:0]),
    .i_wbe   (S_AXI_WSTRB),
    .i_wdata (S_AXI_WDATA),
    .i_re    (w_ld),
    .i_raddr (w_ld_idx[MW-1:0]),
    .o_rdata (w_ram_q)
  );

  // The array output register only advances on a load, so a masked beat stays masked while stalled.
  assign S_AXI_RID   = r_rid;
  assign S_AXI_RDATA = r_rd_zero ? '0 : w_ram_q;
  assign S_AXI_RRESP = r_rresp;
  assign S_AXI_RLAST = r_rlast;

endmodule
